cpu_ctrl_fsm: RTL and testbench

Instruction-sequencing controller for the 8-bit RISC CPU. Runs each two-byte instruction through a fixed 8-state fetch/decode/execute cycle. Drives the strobes for the program counter, instruction register, accumulator, memory read/write and data-bus driver. Uses the same 3-bit opcode the ALU consumes:

- HLT 000, SKZ 001, ADD 010, AND 011, XOR 100, LDA 101, STO 110, JMP 111.

---
 rtl/cpu_ctrl_fsm.sv | 115 +++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
// Instruction sequencer for the 8-bit RISC CPU: an 8-state fetch/decode/execute
// cycle that drives the PC, IR, accumulator, memory and data-bus strobes.
module cpu_ctrl_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       rd,
    output logic       wr,
    output logic       load_ir,
    output logic       load_acc,
    output logic       datactl_ena,
    output logic       halt
);

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [3:0] {
        S0, S1, S2, S3, S4, S5, S6, S7, HALTED
    } state_t;

    state_t     state;
    logic [2:0] op_q;
    logic       zero_q;
    logic       alu_class;

    // Opcode and zero flag are sampled only at the end of the decode slot, so
    // later changes on either input cannot disturb the running instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S0;
            op_q   <= OP_HLT;
            zero_q <= 1'b0;
        end else if (ena) begin
            case (state)
                S0: state <= S1;
                S1: state <= S2;
                S2: begin
                    op_q   <= opcode;
                    zero_q <= zero;
                    state  <= S3;
                end
                S3: state <= (op_q == OP_HLT) ? HALTED : S4;
                S4: state <= S5;
                S5: state <= S6;
                S6: state <= S7;
                S7: state <= S0;
                default: state <= HALTED;
            endcase
        end
    end

    assign alu_class = (op_q == OP_ADD) || (op_q == OP_AND) ||
                       (op_q == OP_XOR) || (op_q == OP_LDA);

    // Strobes are qualified by rst_n and ena so a held reset or a stall shows
    // no activity; halt alone ignores ena so a stopped CPU stays visibly halted.
    always_comb begin
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        load_ir     = 1'b0;
        load_acc    = 1'b0;
        datactl_ena = 1'b0;
        halt        = 1'b0;
        if (rst_n) begin
            halt = (state == HALTED) || ((state == S3) && (op_q == OP_HLT));
            if (ena) begin
                case (state)
                    S0: begin
                        rd      = 1'b1;
                        load_ir = 1'b1;
                    end
                    S1: begin
                        rd      = 1'b1;
                        load_ir = 1'b1;
                        inc_pc  = 1'b1;
                    end
                    S3: inc_pc = 1'b1;
                    S4: begin
                        rd          = alu_class;
                        datactl_ena = (op_q == OP_STO);
                        load_pc     = (op_q == OP_JMP);
                    end
                    S5: begin
                        rd          = alu_class;
                        load_acc    = alu_class;
                        wr          = (op_q == OP_STO);
                        datactl_ena = (op_q == OP_STO);
                        load_pc     = (op_q == OP_JMP);
                        inc_pc      = (op_q == OP_SKZ) && zero_q;
                    end
                    S6: begin
                        rd          = alu_class;
                        datactl_ena = (op_q == OP_STO);
                    end
                    S7: inc_pc = (op_q == OP_SKZ) && zero_q;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed self-checking bench for cpu_ctrl_fsm; the outputs are compared as
// one vector {inc_pc,load_pc,rd,wr,load_ir,load_acc,datactl_ena,halt}.
module tb_cpu_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       inc_pc, load_pc, rd, wr, load_ir, load_acc, datactl_ena, halt;

    int checks = 0;
    int errors = 0;

    // Expected per-state vectors S0..S7, S0 in the most significant byte.
    localparam logic [63:0] EXP_ALU  = 64'h28_A8_00_80_20_24_20_00;
    localparam logic [63:0] EXP_STO  = 64'h28_A8_00_80_02_12_02_00;
    localparam logic [63:0] EXP_SKZ1 = 64'h28_A8_00_80_00_80_00_80;
    localparam logic [63:0] EXP_SKZ0 = 64'h28_A8_00_80_00_00_00_00;
    localparam logic [63:0] EXP_JMP  = 64'h28_A8_00_80_40_40_00_00;

    cpu_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
        .inc_pc(inc_pc), .load_pc(load_pc), .rd(rd), .wr(wr),
        .load_ir(load_ir), .load_acc(load_acc), .datactl_ena(datactl_ena),
        .halt(halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {inc_pc, load_pc, rd, wr, load_ir, load_acc, datactl_ena, halt};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one full instruction from S0, checking every state; optionally
    // toggles zero from S3 onward to show it no longer matters.
    task automatic run_instr(input string name, input logic [2:0] op,
                             input logic z, input logic toggle_zero,
                             input logic [63:0] exp);
        opcode = op;
        zero   = z;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s s%0d", name, i), exp[8*(7-i) +: 8]);
            if (toggle_zero && i >= 3) zero = ~zero;
            tick();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        opcode = 3'b010;
        zero   = 1'b0;
        repeat (3) tick();
        check("reset held", 8'h00);
        rst_n = 1'b1;
        #1;

        run_instr("add", 3'b010, 1'b0, 1'b0, EXP_ALU);
        run_instr("sto", 3'b110, 1'b0, 1'b0, EXP_STO);
        run_instr("skz z1", 3'b001, 1'b1, 1'b1, EXP_SKZ1);
        run_instr("skz z0", 3'b001, 1'b0, 1'b1, EXP_SKZ0);
        run_instr("jmp", 3'b111, 1'b0, 1'b0, EXP_JMP);
        check("after jmp s0", 8'h28);

        // LDA with a three-cycle stall in S5: 11 edges from S0 back to S0.
        opcode = 3'b101;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("lda s%0d", i), EXP_ALU[8*(7-i) +: 8]);
            tick();
        end
        check("lda s5", 8'h24);
        ena = 1'b0;
        #1;
        check("lda stall drop", 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("lda stall %0d", i), 8'h00);
        end
        ena = 1'b1;
        #1;
        check("lda s5 resume", 8'h24);
        tick();
        check("lda s6", 8'h20);
        tick();
        check("lda s7", 8'h00);
        tick();
        check("lda back s0", 8'h28);

        // STO stalled in S5 suppresses wr until ena returns.
        opcode = 3'b110;
        repeat (5) tick();
        check("sto s5", 8'h12);
        ena = 1'b0;
        #1;
        check("sto s5 stalled", 8'h00);
        ena = 1'b1;
        #1;
        check("sto s5 wr back", 8'h12);
        #2;
        rst_n = 1'b0;
        #1;
        check("sto async reset", 8'h00);
        tick();
        check("sto reset held", 8'h00);
        rst_n = 1'b1;
        #1;
        check("restart s0", 8'h28);
        run_instr("add2", 3'b010, 1'b0, 1'b0, EXP_ALU);

        // HLT then HALTED with ena toggling.
        opcode = 3'b000;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hlt s%0d", i), EXP_ALU[8*(7-i) +: 8]);
            tick();
        end
        check("hlt s3", 8'h81);
        tick();
        for (int i = 0; i < 22; i++) begin
            ena    = i[0];
            opcode = 3'b010;
            #1;
            check($sformatf("halted %0d", i), 8'h01);
            tick();
        end
        ena = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("halted async reset", 8'h00);
        rst_n = 1'b1;
        #1;
        check("post halt s0", 8'h28);
        tick();
        check("post halt s1", 8'hA8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
